// File: rtl/cla_pkg.sv
// Shared types and constants for the pipelined carry-lookahead adder/subtractor.
// Covers the operation encoding, the lookahead group width and the stage-count helper.
package cla_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ADC = 2'd2,
    OP_SBB = 2'd3
  } op_e;

  localparam int GRP_W = 4;

  function automatic int nstg(input int width, input int gps);
    return width / (GRP_W * gps);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group.
// Produces the group sum, the group generate/propagate terms and the group carry-out.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GRP_W-1:0] p,
  input  logic [GRP_W-1:0] g,
  input  logic             cin,
  output logic [GRP_W-1:0] sum,
  output logic             G,
  output logic             P,
  output logic             cout
);

  logic [GRP_W-1:0] c;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign G    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign P    = &p;
  assign cout = G | (P & cin);
  assign sum  = p ^ c;

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with an elastic valid/ready chain.
// Each stage resolves GPS 4-bit groups; flags come out of the last stage registers.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GPS   = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  op_e              in_op,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n
);

  localparam int NSTG = nstg(WIDTH, GPS);

  if ((WIDTH % (GRP_W * GPS)) != 0 || WIDTH < (GRP_W * GPS)) begin : g_bad_cfg
    $error("cla_addsub_pipe: WIDTH must be a non-zero multiple of 4*GPS");
  end

  logic [WIDTH-1:0] b_eff, p_in, g_in;
  logic             c_in0;

  always_comb begin
    b_eff = ((in_op == OP_SUB) || (in_op == OP_SBB)) ? ~in_b : in_b;
    c_in0 = 1'b0;
    case (in_op)
      OP_ADD:  c_in0 = 1'b0;
      OP_SUB:  c_in0 = 1'b1;
      OP_ADC:  c_in0 = in_cin;
      OP_SBB:  c_in0 = ~in_cin;
      default: c_in0 = 1'b0;
    endcase
    p_in = in_a ^ b_eff;
    g_in = in_a & b_eff;
  end

  logic             vld_reg [NSTG];
  logic [WIDTH-1:0] sum_reg [NSTG];
  logic [WIDTH-1:0] p_reg   [NSTG];
  logic [WIDTH-1:0] g_reg   [NSTG];
  logic             c_reg   [NSTG];
  logic             z_reg   [NSTG];
  logic [TAG_W-1:0] tag_reg [NSTG];
  logic             v_reg;
  logic [NSTG-1:0]  rdy;

  // A stage may load when it is empty or the stage after it is moving.
  always_comb begin
    rdy[NSTG-1] = !vld_reg[NSTG-1] | out_ready;
    for (int k = NSTG - 2; k >= 0; k--) begin
      rdy[k] = !vld_reg[k] | rdy[k+1];
    end
  end

  for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
    logic [WIDTH-1:0] s_p, s_g, s_sum, st_sum;
    logic             s_c, s_z, s_vld, st_z;
    logic [TAG_W-1:0] s_tag;
    logic [GRP_W-1:0] gsum [GPS];
    logic [GPS-1:0]   grp_gen, grp_prop, grp_cout;
    logic [GPS:0]     gc;

    if (gi == 0) begin : g_src
      assign s_p   = p_in;
      assign s_g   = g_in;
      assign s_sum = '0;
      assign s_c   = c_in0;
      assign s_z   = 1'b1;
      assign s_vld = in_valid;
      assign s_tag = in_tag;
    end else begin : g_src
      assign s_p   = p_reg[gi-1];
      assign s_g   = g_reg[gi-1];
      assign s_sum = sum_reg[gi-1];
      assign s_c   = c_reg[gi-1];
      assign s_z   = z_reg[gi-1];
      assign s_vld = vld_reg[gi-1];
      assign s_tag = tag_reg[gi-1];
    end

    for (genvar gj = 0; gj < GPS; gj++) begin : g_grp
      localparam int LO = (gi * GPS + gj) * GRP_W;
      cla_group4 u_grp (
        .p    (s_p[LO +: GRP_W]),
        .g    (s_g[LO +: GRP_W]),
        .cin  (gc[gj]),
        .sum  (gsum[gj]),
        .G    (grp_gen[gj]),
        .P    (grp_prop[gj]),
        .cout (grp_cout[gj])
      );
    end

    always_comb begin
      gc[0]  = s_c;
      st_sum = s_sum;
      st_z   = s_z;
      for (int j = 0; j < GPS; j++) begin
        gc[j+1] = grp_gen[j] | (grp_prop[j] & gc[j]);
        st_sum[(gi * GPS + j) * GRP_W +: GRP_W] = gsum[j];
        st_z = st_z & ~|gsum[j];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_reg[gi] <= 1'b0;
        sum_reg[gi] <= '0;
        p_reg[gi]   <= '0;
        g_reg[gi]   <= '0;
        c_reg[gi]   <= 1'b0;
        z_reg[gi]   <= 1'b0;
        tag_reg[gi] <= '0;
      end else if (rdy[gi]) begin
        vld_reg[gi] <= s_vld;
        sum_reg[gi] <= st_sum;
        p_reg[gi]   <= s_p;
        g_reg[gi]   <= s_g;
        c_reg[gi]   <= gc[GPS];
        z_reg[gi]   <= st_z;
        tag_reg[gi] <= s_tag;
      end
    end

    if (gi == NSTG - 1) begin : g_flags
      // Carry into the MSB is recovered from its sum bit: sum = p ^ carry_in.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_reg <= 1'b0;
        end else if (rdy[gi]) begin
          v_reg <= gc[GPS] ^ s_p[WIDTH-1] ^ st_sum[WIDTH-1];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_reg[NSTG-1];
  assign out_sum   = sum_reg[NSTG-1];
  assign out_tag   = tag_reg[NSTG-1];
  assign out_c     = c_reg[NSTG-1];
  assign out_v     = v_reg;
  assign out_z     = z_reg[NSTG-1];
  assign out_n     = sum_reg[NSTG-1][WIDTH-1];

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe: arithmetic reference model with an in-order
// scoreboard, directed vectors with literal expectations, backpressure, reset and random traffic.
module tb_cla_addsub_pipe;
  import cla_pkg::*;

  localparam int W    = 32;
  localparam int GP   = 2;
  localparam int T    = 4;
  localparam int NSTG = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  op_e          in_op = OP_ADD;
  logic         in_cin = 1'b0;
  logic [T-1:0] in_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic [T-1:0] out_tag;
  logic         out_c, out_v, out_z, out_n;

  always #5 clk = ~clk;

  cla_addsub_pipe #(.WIDTH(W), .GPS(GP), .TAG_W(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_cin    (in_cin),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_tag   (out_tag),
    .out_c     (out_c),
    .out_v     (out_v),
    .out_z     (out_z),
    .out_n     (out_n)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic [3:0]   flags;  // {c, v, z, n}
    logic [T-1:0] tag;
    int           acc;
  } exp_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int got_cnt = 0;
  int acc_cnt = 0;
  exp_t q[$];
  exp_t e;
  logic [W-1:0] last_sum;
  logic [3:0]   last_flags;
  logic [T-1:0] last_tag;
  int           last_lat;
  bit           prev_stall = 0;
  logic [W-1:0] p_sum;
  logic [7:0]   p_meta;
  bit           rnd_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands, no lookahead structure.
  function automatic exp_t model(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic [T-1:0] tag);
    exp_t   r;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint u, s;
    longint k;
    logic   c;
    k = 0;
    if (op == OP_ADC || op == OP_SBB) k = longint'(cin);
    if (op == OP_ADD || op == OP_ADC) begin
      u = ua + ub + k;
      s = sa + sb + k;
      c = u[32];
    end else begin
      u = ua - ub - k;
      s = sa - sb - k;
      c = (ua >= ub + k);
    end
    r.sum   = u[31:0];
    r.flags = {c, (s > 64'sd2147483647) || (s < -64'sd2147483648), (u[31:0] == 32'd0), u[31]};
    r.tag   = tag;
    r.acc   = 0;
    return r;
  endfunction

  // Compare process: hold check, in-order result check, then record new accepts.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_sum", 64'(out_sum), 64'(p_sum));
          chk("hold_meta", 64'({out_tag, out_c, out_v, out_z, out_n}), 64'(p_meta));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 64'(out_valid), 64'd0);
          end else begin
            e = q.pop_front();
            chk("sum", 64'(out_sum), 64'(e.sum));
            chk("flags_cvzn", 64'({out_c, out_v, out_z, out_n}), 64'(e.flags));
            chk("tag", 64'(out_tag), 64'(e.tag));
            last_sum   = out_sum;
            last_flags = {out_c, out_v, out_z, out_n};
            last_tag   = out_tag;
            last_lat   = cyc - e.acc;
            got_cnt++;
          end
        end
        prev_stall = out_valid && !out_ready;
        p_sum      = out_sum;
        p_meta     = {out_tag, out_c, out_v, out_z, out_n};
        if (in_valid && in_ready) begin
          e = model(in_op, in_a, in_b, in_cin, in_tag);
          e.acc = cyc;
          q.push_back(e);
          acc_cnt++;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting rising edge.
  task automatic send(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic [T-1:0] tag);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cin = cin; in_tag = tag;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) chk("send_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic wait_got(input int target, input string name);
    int  n = 0;
    bit  moved = 0;
    while (got_cnt < target && n < 30000) begin
      @(negedge clk);
      #1;
      n++;
      moved = 1;
    end
    if (got_cnt < target) chk({name, "_timeout"}, 64'(got_cnt), 64'(target));
    if (moved) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic directed(input string name, input op_e op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] x_sum, input logic [3:0] x_flags);
    int base = got_cnt;
    send(op, a, b, cin, 4'hA);
    in_valid = 1'b0;
    wait_got(base + 1, name);
    chk({name, "_sum"}, 64'(last_sum), 64'(x_sum));
    chk({name, "_cvzn"}, 64'(last_flags), 64'(x_flags));
    chk({name, "_latency"}, 64'(last_lat), 64'(NSTG));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int base_got, base_acc;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_flags", 64'({out_c, out_v, out_z, out_n}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    directed("add_wrap",   OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1010);
    directed("sub_ovf",    OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b1100);
    directed("sub_borrow", OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 4'b0001);
    directed("adc_ovf",    OP_ADC, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 4'b0101);
    directed("sbb_small",  OP_SBB, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0001, 4'b1000);
    directed("add_nocin",  OP_ADD, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0002, 4'b0000);
    directed("sub_nocin",  OP_SUB, 32'h0000_0003, 32'h0000_0001, 1'b1, 32'h0000_0002, 4'b1000);
    directed("sub_zero",   OP_SUB, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 4'b1010);
    directed("adc_full",   OP_ADC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 4'b1001);
    directed("sbb_under",  OP_SBB, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 4'b0001);

    // Backpressure: 10 back-to-back ops, consumer stalled for relative cycles 3..9.
    base_got = got_cnt;
    base_acc = acc_cnt;
    fork
      begin
        for (int t = 0; t < 10; t++) send(OP_ADD, 32'h100 * t, W'(t), 1'b0, T'(t));
        in_valid = 1'b0;
      end
      begin
        for (int r = 0; r < 12; r++) begin
          out_ready = !(r >= 3 && r <= 9);
          @(negedge clk);
          if (r == 6) begin
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk("bp_ops_held", 64'(acc_cnt - base_acc), 64'd4);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_got(base_got + 10, "bp_drain");
    chk("bp_last_tag", 64'(last_tag), 64'd9);
    chk("bp_last_sum", 64'(last_sum), 64'h909);

    // Reset with three operations in flight.
    out_ready = 1'b0;
    base_got = got_cnt;
    for (int t = 0; t < 3; t++) send(OP_SUB, 32'h50, W'(t), 1'b0, T'(t + 4));
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("rf_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rf_valid_drop", 64'(out_valid), 64'd0);
    chk("rf_sum_clear", 64'(out_sum), 64'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rf_no_stale", 64'(got_cnt), 64'(base_got));
    chk("rf_idle_valid", 64'(out_valid), 64'd0);
    directed("rf_first", OP_ADD, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 4'b0000);

    // Random traffic with random consumer stalls.
    base_got = got_cnt;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          send(op_e'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)),
               T'($urandom_range(0, 15)));
          if ($urandom_range(0, 7) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_got(base_got + 10000, "rnd_drain");
    chk("rnd_queue_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
